// File: rtl/io_mbox.sv
// Inter-core mailbox: one FIFO per (source, destination) core pair, read through a
// small per-core input address space that also exposes a status/overflow word.
module io_mbox #(
  parameter int NUBITS = 16,
  parameter int NCORE  = 2,
  parameter int FDEPTH = 4,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NCORE*NUBITS-1:0]             io_out,
  input  logic [NCORE*$clog2(NUIOOU)-1:0]     addr_out,
  input  logic [NCORE-1:0]                    out_en,
  input  logic [NCORE*$clog2(NUIOIN)-1:0]     addr_in,
  input  logic [NCORE-1:0]                    req_in,
  output logic [NCORE*NUBITS-1:0]             io_in,
  output logic [NCORE-1:0]                    irq
);

  localparam int AOW = $clog2(NUIOOU);
  localparam int AIW = $clog2(NUIOIN);
  localparam int PW  = $clog2(FDEPTH);
  localparam int CW  = $clog2(FDEPTH + 1);

  logic [NUBITS-1:0] mem_q    [NCORE][NCORE][FDEPTH];
  logic [PW-1:0]     wr_ptr_q [NCORE][NCORE];
  logic [PW-1:0]     wr_ptr_d [NCORE][NCORE];
  logic [PW-1:0]     rd_ptr_q [NCORE][NCORE];
  logic [PW-1:0]     rd_ptr_d [NCORE][NCORE];
  logic [CW-1:0]     count_q  [NCORE][NCORE];
  logic [CW-1:0]     count_d  [NCORE][NCORE];
  logic              ovf_q    [NCORE][NCORE];
  logic              ovf_d    [NCORE][NCORE];
  logic              push_ok  [NCORE][NCORE];
  logic              pop_ok   [NCORE][NCORE];

  int                out_addr [NCORE];
  int                in_addr  [NCORE];
  logic [NUBITS-1:0] status;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < NCORE; c++) begin
      out_addr[c] = int'(addr_out[c*AOW +: AOW]);
      in_addr[c]  = int'(addr_in[c*AIW +: AIW]);
    end
  end

  // A push into a full channel only succeeds when the same edge pops it.
  always_comb begin
    logic push;
    logic full;
    push     = 1'b0;
    full     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    push_ok  = '{default: 1'b0};
    pop_ok   = '{default: 1'b0};
    for (int s = 0; s < NCORE; s++) begin
      for (int d = 0; d < NCORE; d++) begin
        push          = out_en[s] && (out_addr[s] == d);
        full          = (count_q[s][d] == CW'(FDEPTH));
        pop_ok[s][d]  = req_in[d] && (in_addr[d] == s) && (count_q[s][d] != '0);
        push_ok[s][d] = push && (!full || pop_ok[s][d]);
        if (push_ok[s][d]) wr_ptr_d[s][d] = next_ptr(wr_ptr_q[s][d]);
        if (pop_ok[s][d])  rd_ptr_d[s][d] = next_ptr(rd_ptr_q[s][d]);
        if (push_ok[s][d] && !pop_ok[s][d])
          count_d[s][d] = count_q[s][d] + 1'b1;
        else if (pop_ok[s][d] && !push_ok[s][d])
          count_d[s][d] = count_q[s][d] - 1'b1;
        if (push && full && !pop_ok[s][d])
          ovf_d[s][d] = 1'b1;
        else if (req_in[d] && (in_addr[d] == NCORE))
          ovf_d[s][d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NCORE; s++) begin
        for (int d = 0; d < NCORE; d++) begin
          wr_ptr_q[s][d] <= '0;
          rd_ptr_q[s][d] <= '0;
          count_q[s][d]  <= '0;
          ovf_q[s][d]    <= 1'b0;
        end
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left unreset; an empty channel never exposes it.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NCORE; s++) begin
      for (int d = 0; d < NCORE; d++) begin
        if (push_ok[s][d])
          mem_q[s][d][wr_ptr_q[s][d]] <= io_out[s*NUBITS +: NUBITS];
      end
    end
  end

  always_comb begin
    io_in  = '0;
    irq    = '0;
    status = '0;
    for (int d = 0; d < NCORE; d++) begin
      status = '0;
      for (int s = 0; s < NCORE; s++) begin
        if (count_q[s][d] != '0) begin
          irq[d]    = 1'b1;
          status[s] = 1'b1;
        end
        status[NCORE+s] = ovf_q[s][d];
        if ((in_addr[d] == s) && (count_q[s][d] != '0))
          io_in[d*NUBITS +: NUBITS] = mem_q[s][d][rd_ptr_q[s][d]];
      end
      if (in_addr[d] == NCORE)
        io_in[d*NUBITS +: NUBITS] = status;
    end
  end

endmodule

// File: tb/tb_io_mbox.sv
// Self-checking bench for io_mbox (NCORE=2, FDEPTH=4, NUBITS=16): queue-based
// reference model compared every cycle, plus hand-computed directed expectations.
module tb_io_mbox;

  localparam int NCORE  = 2;
  localparam int NUBITS = 16;
  localparam int FDEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] io_out;
  logic [5:0]  addr_out;
  logic [1:0]  out_en;
  logic [5:0]  addr_in;
  logic [1:0]  req_in;
  logic [31:0] io_in;
  logic [1:0]  irq;

  int compared;
  int mismatched;

  logic [15:0] mq   [2][2][$];
  bit          movf [2][2];

  io_mbox #(
    .NUBITS(NUBITS), .NCORE(NCORE), .FDEPTH(FDEPTH), .NUIOIN(8), .NUIOOU(8)
  ) dut (
    .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .addr_in(addr_in), .req_in(req_in), .io_in(io_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=0x%04h required=0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setInputs(input logic [1:0] we, input logic [15:0] d0, input logic [2:0] ao0,
                           input logic [15:0] d1, input logic [2:0] ao1,
                           input logic [1:0] re, input logic [2:0] ai0, input logic [2:0] ai1);
    out_en   = we;
    io_out   = {d1, d0};
    addr_out = {ao1, ao0};
    req_in   = re;
    addr_in  = {ai1, ai0};
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [15:0] d0, input logic [2:0] ao0,
                               input logic [15:0] d1, input logic [2:0] ao1,
                               input logic [1:0] re, input logic [2:0] ai0, input logic [2:0] ai1);
    @(negedge clk);
    setInputs(we, d0, ao0, d1, ao1, re, ai0, ai1);
  endtask

  task automatic idleCycle();
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
  endtask

  // Reference model: plain queues per channel, stepped at every rising edge.
  task automatic modelClear();
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 2; d++) begin
        mq[s][d].delete();
        movf[s][d] = 1'b0;
      end
  endtask

  task automatic modelStep();
    bit wantPush [2][2];
    bit doPop    [2][2];
    bit clr;
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 2; d++) begin
        wantPush[s][d] = out_en[s] && (int'(addr_out[s*3 +: 3]) == d);
        doPop[s][d]    = req_in[d] && (int'(addr_in[d*3 +: 3]) == s) && (mq[s][d].size() > 0);
      end
    for (int s = 0; s < 2; s++)
      for (int d = 0; d < 2; d++) begin
        clr = req_in[d] && (int'(addr_in[d*3 +: 3]) == NCORE);
        if (doPop[s][d]) void'(mq[s][d].pop_front());
        if (wantPush[s][d] && mq[s][d].size() < FDEPTH)
          mq[s][d].push_back(io_out[s*16 +: 16]);
        else if (wantPush[s][d])
          movf[s][d] = 1'b1;
        else if (clr)
          movf[s][d] = 1'b0;
        if (clr && !(wantPush[s][d] && movf[s][d] && mq[s][d].size() == FDEPTH && !doPop[s][d]))
          ;
      end
  endtask

  function automatic logic [15:0] expIoIn(input int d);
    int a;
    logic [15:0 ] st;
    a  = int'(addr_in[d*3 +: 3]);
    st = '0;
    if (a < NCORE) return (mq[a][d].size() > 0) ? mq[a][d][0] : 16'h0;
    if (a == NCORE) begin
      for (int s = 0; s < NCORE; s++) begin
        st[s]       = (mq[s][d].size() > 0);
        st[NCORE+s] = movf[s][d];
      end
      return st;
    end
    return 16'h0;
  endfunction

  function automatic logic [15:0] expIrq();
    logic [15:0] r;
    r = '0;
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++)
        if (mq[s][d].size() > 0) r[d] = 1'b1;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) modelClear();
      else modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      checkOutput("model_io_in0", io_in[15:0], expIoIn(0));
      checkOutput("model_io_in1", io_in[31:16], expIoIn(1));
      checkOutput("model_irq", {14'b0, irq}, expIrq());
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst = 1'b1;
    setInputs(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd0, 3'd2);
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_irq", {14'b0, irq}, 16'h0);
    checkOutput("reset_io_in0", io_in[15:0], 16'h0);
    checkOutput("reset_status1", io_in[31:16], 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single word core0 -> core1
    applyStimulus(2'b01, 16'h1111, 3'd1, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
    #2;
    checkOutput("single_irq", {14'b0, irq}, 16'h0002);
    checkOutput("single_data", io_in[31:16], 16'h1111);
    idleCycle();
    #2;
    checkOutput("single_irq_after_pop", {14'b0, irq}, 16'h0);

    // Overflow on the fifth write
    for (int i = 0; i < 5; i++)
      applyStimulus(2'b01, 16'(16'hA0 + i), 3'd1, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd2);
    #2;
    checkOutput("ovf_status", io_in[31:16], 16'h0005);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
      #2;
      checkOutput("ovf_drain", io_in[31:16], 16'(16'hA0 + i));
    end
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
    #2;
    checkOutput("ovf_empty_read", io_in[31:16], 16'h0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd0, 3'd2);
    #2;
    checkOutput("ovf_cleared", io_in[31:16], 16'h0);

    // Push and pop on a full channel in one cycle
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b01, 16'(16'hC0 + i), 3'd1, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b01, 16'h00B0, 3'd1, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
    #2;
    checkOutput("full_pp_head", io_in[31:16], 16'h00C0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd0, 3'd2);
    #2;
    checkOutput("full_pp_status", io_in[31:16], 16'h0001);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
      #2;
      checkOutput("full_pp_drain", io_in[31:16], (i < 4) ? 16'(16'hC0 + i) : 16'h00B0);
    end
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
    #2;
    checkOutput("full_pp_empty", io_in[31:16], 16'h0);

    // Loopback and cross traffic in the same cycles, plus an ignored address
    applyStimulus(2'b11, 16'h0100, 3'd0, 16'h1100, 3'd1, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b11, 16'h0101, 3'd1, 16'h1001, 3'd0, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b11, 16'h0102, 3'd0, 16'h1002, 3'd0, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b01, 16'hDEAD, 3'd5, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
    #2;
    checkOutput("mix_irq", {14'b0, irq}, 16'h0003);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b11, 3'd0, 3'd1);
    #2;
    checkOutput("mix_c0_r1", io_in[15:0], 16'h0100);
    checkOutput("mix_c1_r1", io_in[31:16], 16'h1100);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b11, 3'd0, 3'd0);
    #2;
    checkOutput("mix_c0_r2", io_in[15:0], 16'h0102);
    checkOutput("mix_c1_r2", io_in[31:16], 16'h0101);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b11, 3'd1, 3'd0);
    #2;
    checkOutput("mix_c0_r3", io_in[15:0], 16'h1001);
    checkOutput("mix_c1_r3", io_in[31:16], 16'h0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b11, 3'd1, 3'd6);
    #2;
    checkOutput("mix_c0_r4", io_in[15:0], 16'h1002);
    checkOutput("mix_c1_addr6", io_in[31:16], 16'h0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd2, 3'd2);
    #2;
    checkOutput("mix_irq_end", {14'b0, irq}, 16'h0);
    checkOutput("mix_status0", io_in[15:0], 16'h0);

    // Status-read clear coinciding with an overflow
    for (int i = 0; i < 4; i++)
      applyStimulus(2'b10, 16'h0, 3'd0, 16'(16'hE0 + i), 3'd0, 2'b00, 3'd0, 3'd0);
    applyStimulus(2'b10, 16'h0, 3'd0, 16'h00E4, 3'd0, 2'b01, 3'd2, 3'd0);
    #2;
    checkOutput("clr_ovf_before", io_in[15:0], 16'h0002);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd2, 3'd0);
    #2;
    checkOutput("clr_ovf_kept", io_in[15:0], 16'h000A);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b01, 3'd2, 3'd0);
    #2;
    checkOutput("clr_ovf_read", io_in[15:0], 16'h000A);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b00, 3'd2, 3'd0);
    #2;
    checkOutput("clr_ovf_gone", io_in[15:0], 16'h0002);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b01, 3'd1, 3'd0);
      #2;
      checkOutput("clr_drain", io_in[15:0], 16'(16'hE0 + i));
    end
    idleCycle();
    #2;
    checkOutput("clr_irq_end", {14'b0, irq}, 16'h0);

    // Asynchronous reset with words queued
    for (int i = 0; i < 3; i++)
      applyStimulus(2'b01, 16'(16'hF0 + i), 3'd1, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
    idleCycle();
    #2;
    checkOutput("arst_head_before", io_in[31:16], 16'h00F0);
    checkOutput("arst_irq_before", {14'b0, irq}, 16'h0002);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_irq", {14'b0, irq}, 16'h0);
    checkOutput("arst_io_in1", io_in[31:16], 16'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    setInputs(2'b01, 16'h7777, 3'd1, 16'h0, 3'd0, 2'b00, 3'd0, 3'd0);
    #2;
    checkOutput("arst_after_read", io_in[31:16], 16'h0);
    checkOutput("arst_after_irq", {14'b0, irq}, 16'h0);
    applyStimulus(2'b00, 16'h0, 3'd0, 16'h0, 3'd0, 2'b10, 3'd0, 3'd0);
    #2;
    checkOutput("first_push_data", io_in[31:16], 16'h7777);
    checkOutput("first_push_irq", {14'b0, irq}, 16'h0002);
    idleCycle();
    #2;
    checkOutput("final_irq", {14'b0, irq}, 16'h0);
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
